// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU operation encodings and the
// operand forwarding source selector used by the EX operand stage.
package riscv_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_EQ   = 4'b1000;
  localparam logic [3:0] ALU_ADDI = 4'b1001;

  // Where an ALU operand comes from: the value read in ID, or a newer
  // result still travelling down the pipe.
  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/forward_unit.sv
// Picks the forwarding source for one source register. The newest producer
// (EX/MEM) wins over MEM/WB, and x0 is never forwarded since it reads as 0.
import riscv_pkg::*;

module forward_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_regwrite,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_regwrite,
  output fwd_sel_e              sel
);

  // Compare the source index against both in-flight destinations.
  always_comb begin
    sel = FWD_RF;
    if (exmem_regwrite && (exmem_rd == rs) && (rs != '0)) begin
      sel = FWD_EXMEM;
    end else if (memwb_regwrite && (memwb_rd == rs) && (rs != '0)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX stage register plus operand forwarding and load-use hazard
// detection. The registered fields feed the ALU operand muxes in the same
// cycle, so forwarding adds no latency.
import riscv_pkg::*;

module ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_alusrc,
  input  logic [OPCODE_LENGTH-1:0] id_operation,
  input  logic                     id_memread,
  input  logic                     id_regwrite,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic                     exmem_regwrite,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic                     memwb_regwrite,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic                     stall,
  output logic                     ex_valid,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_regwrite,
  output logic                     ex_memread,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation
);

  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [DATA_WIDTH-1:0] ex_rs1_data;
  logic [DATA_WIDTH-1:0] ex_rs2_data;
  logic [DATA_WIDTH-1:0] ex_imm;
  logic                  ex_alusrc;
  logic [DATA_WIDTH-1:0] fwd_b;
  fwd_sel_e              sel_a;
  fwd_sel_e              sel_b;

  // A load in EX whose result the ID instruction needs cannot be forwarded
  // in time; hold ID for one cycle. A flush discards ID anyway, so no stall.
  always_comb begin
    stall = ex_valid && ex_memread && (ex_rd != '0) && id_valid &&
            ((id_rs1 == ex_rd) || (id_rs2 == ex_rd)) && !flush;
  end

  // Stage register: reset, flush and stall all load a bubble; otherwise the
  // ID instruction is captured.
  always_ff @(posedge clk) begin
    if (reset || flush || stall) begin
      ex_valid    <= 1'b0;
      ex_rd       <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_alusrc   <= 1'b0;
      Operation   <= '0;
    end else begin
      ex_valid    <= id_valid;
      ex_rd       <= id_rd;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_alusrc   <= id_alusrc;
      Operation   <= id_operation;
    end
  end

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs             (ex_rs1),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .sel            (sel_a)
  );

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs             (ex_rs2),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .sel            (sel_b)
  );

  // Operand muxes: apply the forwarding choice, then the immediate select on B.
  always_comb begin
    SrcA  = ex_rs1_data;
    fwd_b = ex_rs2_data;
    case (sel_a)
      FWD_EXMEM: SrcA = exmem_result;
      FWD_MEMWB: SrcA = memwb_result;
      default:   SrcA = ex_rs1_data;
    endcase
    case (sel_b)
      FWD_EXMEM: fwd_b = exmem_result;
      FWD_MEMWB: fwd_b = memwb_result;
      default:   fwd_b = ex_rs2_data;
    endcase
    SrcB = ex_alusrc ? ex_imm : fwd_b;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed testbench for ex_operand_stage: reset, capture, forwarding
// priority, x0 handling, load-use stall, flush, immediate select and
// reset during a stall.
import riscv_pkg::*;

module tb_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic        id_alusrc;
  logic [3:0]  id_operation;
  logic        id_memread;
  logic        id_regwrite;
  logic [4:0]  exmem_rd;
  logic        exmem_regwrite;
  logic [31:0] exmem_result;
  logic [4:0]  memwb_rd;
  logic        memwb_regwrite;
  logic [31:0] memwb_result;
  logic        stall;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  Operation;

  int errors = 0;
  int checks = 0;

  ex_operand_stage #(
    .DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_W(5)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_operation(id_operation),
    .id_memread(id_memread), .id_regwrite(id_regwrite),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .exmem_result(exmem_result), .memwb_rd(memwb_rd),
    .memwb_regwrite(memwb_regwrite), .memwb_result(memwb_result),
    .stall(stall), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic alusrc,
                               input logic [3:0] op, input logic mr,
                               input logic rw);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_rs1_data  = d1;
    id_rs2_data  = d2;
    id_imm       = imm;
    id_alusrc    = alusrc;
    id_operation = op;
    id_memread   = mr;
    id_regwrite  = rw;
  endtask

  task automatic setForward(input logic erw, input logic [4:0] erd,
                            input logic [31:0] eres, input logic mrw,
                            input logic [4:0] mrd, input logic [31:0] mres);
    exmem_regwrite = erw;
    exmem_rd       = erd;
    exmem_result   = eres;
    memwb_regwrite = mrw;
    memwb_rd       = mrd;
    memwb_result   = mres;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1, ALU_ADD, 1, 1);
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", ex_valid); end
    checks++; if (SrcA !== 32'h0) begin errors++; $display("[TB] FAIL reset_srca: got %h expected 0", SrcA); end
    checks++; if (SrcB !== 32'h0) begin errors++; $display("[TB] FAIL reset_srcb: got %h expected 0", SrcB); end
    checks++; if (Operation !== 4'b0000) begin errors++; $display("[TB] FAIL reset_op: got %b expected 0000", Operation); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
    reset = 1'b0;
  endtask

  task automatic test_add();
    applyStimulus(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 0, ALU_ADD, 0, 1);
    tick();
    checks++; if (SrcA !== 32'd5) begin errors++; $display("[TB] FAIL add_srca: got %h expected 5", SrcA); end
    checks++; if (SrcB !== 32'd7) begin errors++; $display("[TB] FAIL add_srcb: got %h expected 7", SrcB); end
    checks++; if (Operation !== 4'b0010) begin errors++; $display("[TB] FAIL add_op: got %b expected 0010", Operation); end
    checks++; if (ex_rd !== 5'd3) begin errors++; $display("[TB] FAIL add_rd: got %0d expected 3", ex_rd); end
    checks++; if ({ex_valid, ex_regwrite, ex_memread} !== 3'b110) begin errors++; $display("[TB] FAIL add_ctrl: got %b expected 110", {ex_valid, ex_regwrite, ex_memread}); end
  endtask

  task automatic test_forward();
    applyStimulus(1, 5'd1, 5'd2, 5'd9, 32'hAA, 32'hBB, 32'h0, 0, ALU_SUB, 0, 1);
    tick();
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, ALU_AND, 0, 0);
    checks++; if (Operation !== 4'b0011) begin errors++; $display("[TB] FAIL fwd_op: got %b expected 0011", Operation); end
    setForward(1, 5'd1, 32'h10, 1, 5'd1, 32'h20);
    #1;
    checks++; if (SrcA !== 32'h10) begin errors++; $display("[TB] FAIL fwd_exmem_prio: got %h expected 10", SrcA); end
    setForward(0, 5'd1, 32'h10, 1, 5'd1, 32'h20);
    #1;
    checks++; if (SrcA !== 32'h20) begin errors++; $display("[TB] FAIL fwd_memwb: got %h expected 20", SrcA); end
    setForward(1, 5'd2, 32'h30, 0, 5'd0, 32'h0);
    #1;
    checks++; if (SrcB !== 32'h30) begin errors++; $display("[TB] FAIL fwd_b_exmem: got %h expected 30", SrcB); end
    checks++; if (SrcA !== 32'hAA) begin errors++; $display("[TB] FAIL fwd_a_nomatch: got %h expected aa", SrcA); end
    setForward(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    #1;
    checks++; if (SrcB !== 32'hBB) begin errors++; $display("[TB] FAIL fwd_b_rf: got %h expected bb", SrcB); end
    // Sources are x0: an EX/MEM or MEM/WB write to x0 must not forward.
    applyStimulus(1, 5'd0, 5'd0, 5'd8, 32'h55, 32'h66, 32'h0, 0, ALU_XOR, 0, 1);
    tick();
    setForward(1, 5'd0, 32'h99, 1, 5'd0, 32'h77);
    #1;
    checks++; if (SrcA !== 32'h55) begin errors++; $display("[TB] FAIL fwd_x0_a: got %h expected 55", SrcA); end
    checks++; if (SrcB !== 32'h66) begin errors++; $display("[TB] FAIL fwd_x0_b: got %h expected 66", SrcB); end
    setForward(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
  endtask

  task automatic test_load_use();
    applyStimulus(1, 5'd2, 5'd0, 5'd4, 32'h100, 32'h0, 32'h8, 1, ALU_ADD, 1, 1);
    tick();
    applyStimulus(1, 5'd4, 5'd1, 5'd5, 32'h11, 32'h22, 32'h0, 0, ALU_ADD, 0, 1);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall: got %b expected 1", stall); end
    tick();
    checks++; if ({ex_valid, ex_regwrite} !== 2'b00) begin errors++; $display("[TB] FAIL lu_bubble: got %b expected 00", {ex_valid, ex_regwrite}); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall_drop: got %b expected 0", stall); end
    tick();
    checks++; if ({ex_valid, ex_rd} !== {1'b1, 5'd5}) begin errors++; $display("[TB] FAIL lu_capture: got %b/%0d expected 1/5", ex_valid, ex_rd); end
    checks++; if (SrcA !== 32'h11) begin errors++; $display("[TB] FAIL lu_srca: got %h expected 11", SrcA); end
  endtask

  task automatic test_flush();
    applyStimulus(1, 5'd2, 5'd0, 5'd4, 32'h100, 32'h0, 32'h8, 1, ALU_ADD, 1, 1);
    tick();
    applyStimulus(1, 5'd4, 5'd1, 5'd5, 32'h11, 32'h22, 32'h0, 0, ALU_ADD, 0, 1);
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall: got %b expected 0", stall); end
    tick();
    flush = 1'b0;
    checks++; if ({ex_valid, ex_memread, ex_regwrite} !== 3'b000) begin errors++; $display("[TB] FAIL flush_bubble: got %b expected 000", {ex_valid, ex_memread, ex_regwrite}); end
    checks++; if (ex_rd !== 5'd0) begin errors++; $display("[TB] FAIL flush_rd: got %0d expected 0", ex_rd); end
    checks++; if (SrcA !== 32'h0) begin errors++; $display("[TB] FAIL flush_srca: got %h expected 0", SrcA); end
  endtask

  task automatic test_addi();
    applyStimulus(1, 5'd6, 5'd7, 5'd10, 32'h40, 32'h1234, 32'hFFFFFFFC, 1, ALU_ADDI, 0, 1);
    tick();
    setForward(1, 5'd7, 32'hDEAD, 1, 5'd7, 32'hBEEF);
    #1;
    checks++; if (SrcB !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL addi_srcb: got %h expected fffffffc", SrcB); end
    checks++; if (SrcA !== 32'h40) begin errors++; $display("[TB] FAIL addi_srca: got %h expected 40", SrcA); end
    checks++; if (Operation !== 4'b1001) begin errors++; $display("[TB] FAIL addi_op: got %b expected 1001", Operation); end
    setForward(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
  endtask

  task automatic test_reset_mid_stall();
    applyStimulus(1, 5'd2, 5'd0, 5'd4, 32'h100, 32'h0, 32'h8, 1, ALU_ADD, 1, 1);
    tick();
    applyStimulus(1, 5'd1, 5'd4, 5'd5, 32'h11, 32'h22, 32'h0, 0, ALU_ADD, 0, 1);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL rms_stall_before: got %b expected 1", stall); end
    reset = 1'b1;
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rms_stall: got %b expected 0", stall); end
    checks++; if ({ex_valid, ex_regwrite, ex_memread, ex_rd} !== 8'h00) begin errors++; $display("[TB] FAIL rms_ctrl: got %h expected 00", {ex_valid, ex_regwrite, ex_memread, ex_rd}); end
    checks++; if ({SrcA, SrcB, Operation} !== 68'h0) begin errors++; $display("[TB] FAIL rms_data: got %h/%h/%b expected 0", SrcA, SrcB, Operation); end
    reset = 1'b0;
  endtask

  // Run the scenarios in order and print the summary.
  initial begin
    reset = 1'b1;
    flush = 1'b0;
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, ALU_AND, 0, 0);
    setForward(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_flush();
    test_addi();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
